panel_switch_debounce: RTL and testbench



---
 rtl/panel_switch_debounce_if.sv | 26 ++
 rtl/panel_switch_debounce.sv | 128 ++++++++++++
 tb/tb_panel_switch_debounce.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/panel_switch_debounce_if.sv
// rtl/panel_switch_debounce_if.sv - raw scan words in, debounced levels and event pulses out
interface panel_switch_debounce_if;
    logic [15:0] raw_0, raw_1, raw_2, raw_3, raw_4;
    logic [15:0] level_0, level_1, level_2, level_3, level_4;
    logic [15:0] press_0, press_1, press_2, press_3, press_4;
    logic [15:0] release_0, release_1, release_2, release_3, release_4;
    logic        any_event;
    logic        ready;
    logic        tick;

    modport master (
        output raw_0, raw_1, raw_2, raw_3, raw_4,
        input  level_0, level_1, level_2, level_3, level_4,
        input  press_0, press_1, press_2, press_3, press_4,
        input  release_0, release_1, release_2, release_3, release_4,
        input  any_event, ready, tick
    );

    modport slave (
        input  raw_0, raw_1, raw_2, raw_3, raw_4,
        output level_0, level_1, level_2, level_3, level_4,
        output press_0, press_1, press_2, press_3, press_4,
        output release_0, release_1, release_2, release_3, release_4,
        output any_event, ready, tick
    );
endinterface

// File: rtl/panel_switch_debounce.sv
// rtl/panel_switch_debounce.sv - per-bit sampled stability filter for the five front-panel scan words
module panel_switch_debounce #(
    parameter int TICK_DIV   = 50000,
    parameter int STABLE_CNT = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    panel_switch_debounce_if.slave  sw
);
    localparam int             TW        = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [3:0]     CNT_LAST  = 4'(STABLE_CNT - 1);

    logic [15:0]   raw       [5];
    logic [15:0]   level_q   [5];
    logic [15:0]   level_d   [5];
    logic [15:0]   press_q   [5];
    logic [15:0]   press_d   [5];
    logic [15:0]   release_q [5];
    logic [15:0]   release_d [5];
    logic [3:0]    cnt_q     [5][16];
    logic [3:0]    cnt_d     [5][16];
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic          tick_q, tick_d;
    logic          primed_q, primed_d;
    logic          any_q, any_d;

    assign raw[0] = sw.raw_0;
    assign raw[1] = sw.raw_1;
    assign raw[2] = sw.raw_2;
    assign raw[3] = sw.raw_3;
    assign raw[4] = sw.raw_4;

    always_comb begin
        tick_cnt_d = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + TW'(1);
        tick_d     = (tick_cnt_q == TICK_LAST);
    end

    // The first tick only captures the current switch positions so that
    // switches already on at power-up do not produce a press.
    always_comb begin
        primed_d = primed_q;
        any_d    = 1'b0;
        for (int w = 0; w < 5; w++) begin
            level_d[w]   = level_q[w];
            press_d[w]   = '0;
            release_d[w] = '0;
            for (int b = 0; b < 16; b++) begin
                cnt_d[w][b] = cnt_q[w][b];
            end
        end
        if (tick_q) begin
            if (!primed_q) begin
                primed_d = 1'b1;
                for (int w = 0; w < 5; w++) begin
                    level_d[w] = raw[w];
                end
            end else begin
                for (int w = 0; w < 5; w++) begin
                    for (int b = 0; b < 16; b++) begin
                        if (raw[w][b] == level_q[w][b]) begin
                            cnt_d[w][b] = '0;
                        end else if (cnt_q[w][b] == CNT_LAST) begin
                            cnt_d[w][b]      = '0;
                            level_d[w][b]    = raw[w][b];
                            press_d[w][b]    = raw[w][b];
                            release_d[w][b]  = ~raw[w][b];
                        end else begin
                            cnt_d[w][b] = cnt_q[w][b] + 4'd1;
                        end
                    end
                end
            end
        end
        for (int w = 0; w < 5; w++) begin
            any_d = any_d | (|press_d[w]) | (|release_d[w]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt_q <= '0;
            tick_q     <= 1'b0;
            primed_q   <= 1'b0;
            any_q      <= 1'b0;
            for (int w = 0; w < 5; w++) begin
                level_q[w]   <= '0;
                press_q[w]   <= '0;
                release_q[w] <= '0;
                for (int b = 0; b < 16; b++) begin
                    cnt_q[w][b] <= '0;
                end
            end
        end else begin
            tick_cnt_q <= tick_cnt_d;
            tick_q     <= tick_d;
            primed_q   <= primed_d;
            any_q      <= any_d;
            for (int w = 0; w < 5; w++) begin
                level_q[w]   <= level_d[w];
                press_q[w]   <= press_d[w];
                release_q[w] <= release_d[w];
                for (int b = 0; b < 16; b++) begin
                    cnt_q[w][b] <= cnt_d[w][b];
                end
            end
        end
    end

    assign sw.level_0   = level_q[0];
    assign sw.level_1   = level_q[1];
    assign sw.level_2   = level_q[2];
    assign sw.level_3   = level_q[3];
    assign sw.level_4   = level_q[4];
    assign sw.press_0   = press_q[0];
    assign sw.press_1   = press_q[1];
    assign sw.press_2   = press_q[2];
    assign sw.press_3   = press_q[3];
    assign sw.press_4   = press_q[4];
    assign sw.release_0 = release_q[0];
    assign sw.release_1 = release_q[1];
    assign sw.release_2 = release_q[2];
    assign sw.release_3 = release_q[3];
    assign sw.release_4 = release_q[4];
    assign sw.any_event = any_q;
    assign sw.ready     = primed_q;
    assign sw.tick      = tick_q;
endmodule

// File: tb/tb_panel_switch_debounce.sv
// tb/tb_panel_switch_debounce.sv - two debouncer configurations against a run-length reference model
module tb_panel_switch_debounce;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    panel_switch_debounce_if bus_a ();
    panel_switch_debounce_if bus_b ();

    panel_switch_debounce #(.TICK_DIV(4), .STABLE_CNT(3)) u_a (.clk(clk), .reset(reset), .sw(bus_a));
    panel_switch_debounce #(.TICK_DIV(2), .STABLE_CNT(1)) u_b (.clk(clk), .reset(reset), .sw(bus_b));

    logic [15:0] raw_tb [2][5];
    logic [15:0] lvl [2][5];
    logic [15:0] prs [2][5];
    logic [15:0] rls [2][5];
    logic        anyv [2];
    logic        rdy [2];
    logic        tck [2];

    assign bus_a.raw_0 = raw_tb[0][0];
    assign bus_a.raw_1 = raw_tb[0][1];
    assign bus_a.raw_2 = raw_tb[0][2];
    assign bus_a.raw_3 = raw_tb[0][3];
    assign bus_a.raw_4 = raw_tb[0][4];
    assign bus_b.raw_0 = raw_tb[1][0];
    assign bus_b.raw_1 = raw_tb[1][1];
    assign bus_b.raw_2 = raw_tb[1][2];
    assign bus_b.raw_3 = raw_tb[1][3];
    assign bus_b.raw_4 = raw_tb[1][4];

    assign lvl[0] = '{bus_a.level_0, bus_a.level_1, bus_a.level_2, bus_a.level_3, bus_a.level_4};
    assign prs[0] = '{bus_a.press_0, bus_a.press_1, bus_a.press_2, bus_a.press_3, bus_a.press_4};
    assign rls[0] = '{bus_a.release_0, bus_a.release_1, bus_a.release_2, bus_a.release_3, bus_a.release_4};
    assign lvl[1] = '{bus_b.level_0, bus_b.level_1, bus_b.level_2, bus_b.level_3, bus_b.level_4};
    assign prs[1] = '{bus_b.press_0, bus_b.press_1, bus_b.press_2, bus_b.press_3, bus_b.press_4};
    assign rls[1] = '{bus_b.release_0, bus_b.release_1, bus_b.release_2, bus_b.release_3, bus_b.release_4};
    assign anyv[0] = bus_a.any_event;
    assign anyv[1] = bus_b.any_event;
    assign rdy[0]  = bus_a.ready;
    assign rdy[1]  = bus_b.ready;
    assign tck[0]  = bus_a.tick;
    assign tck[1]  = bus_b.tick;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: n counts clock edges since reset released; a bit flips
    // once it has been seen differing from its level on sc consecutive ticks.
    int          td [2] = '{4, 2};
    int          sc [2] = '{3, 1};
    int          n [2];
    bit          primed [2];
    logic [15:0] m_level [2][5];
    logic [15:0] m_press [2][5];
    logic [15:0] m_rel [2][5];
    int          run [2][5][16];
    logic        m_any [2];
    logic        m_tick [2];

    typedef struct {
        logic [15:0] raw;
        logic [15:0] lvl;
        logic [15:0] prs;
        logic [15:0] rls;
    } vec_t;
    vec_t tbl [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_tick(input int d);
        return (n[d] > 0) && (n[d] % td[d] == 0);
    endfunction

    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                n[d] = 0;
                primed[d] = 1'b0;
                m_any[d] = 1'b0;
                m_tick[d] = 1'b0;
                for (int w = 0; w < 5; w++) begin
                    m_level[d][w] = '0;
                    m_press[d][w] = '0;
                    m_rel[d][w] = '0;
                    for (int b = 0; b < 16; b++) run[d][w][b] = 0;
                end
            end else begin
                bit tk;
                tk = is_tick(d);
                m_any[d] = 1'b0;
                for (int w = 0; w < 5; w++) begin
                    m_press[d][w] = '0;
                    m_rel[d][w] = '0;
                end
                if (tk && !primed[d]) begin
                    primed[d] = 1'b1;
                    for (int w = 0; w < 5; w++) m_level[d][w] = raw_tb[d][w];
                end else if (tk) begin
                    for (int w = 0; w < 5; w++) begin
                        for (int b = 0; b < 16; b++) begin
                            if (raw_tb[d][w][b] != m_level[d][w][b]) run[d][w][b]++;
                            else run[d][w][b] = 0;
                            if (run[d][w][b] == sc[d]) begin
                                run[d][w][b] = 0;
                                m_level[d][w][b] = raw_tb[d][w][b];
                                if (raw_tb[d][w][b]) m_press[d][w][b] = 1'b1;
                                else m_rel[d][w][b] = 1'b1;
                                m_any[d] = 1'b1;
                            end
                        end
                    end
                end
                n[d]++;
                m_tick[d] = (n[d] % td[d] == 0);
            end
        end
    endtask

    task automatic compare_all();
        for (int d = 0; d < 2; d++) begin
            for (int w = 0; w < 5; w++) begin
                chk($sformatf("d%0d_level_%0d", d, w), 32'(lvl[d][w]), 32'(m_level[d][w]));
                chk($sformatf("d%0d_press_%0d", d, w), 32'(prs[d][w]), 32'(m_press[d][w]));
                chk($sformatf("d%0d_release_%0d", d, w), 32'(rls[d][w]), 32'(m_rel[d][w]));
            end
            chk($sformatf("d%0d_any_event", d), 32'(anyv[d]), 32'(m_any[d]));
            chk($sformatf("d%0d_ready", d), 32'(rdy[d]), 32'(primed[d]));
            chk($sformatf("d%0d_tick", d), 32'(tck[d]), 32'(m_tick[d]));
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    // Advances until just after the edge that consumed a tick of DUT d.
    task automatic tick_wait(input int d);
        bit was;
        for (int i = 0; i < 20; i++) begin
            was = is_tick(d);
            step();
            if (was) return;
        end
        chk("tick_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{16'h0080, 16'h0080, 16'h0080, 16'h0000};
        tbl[1] = '{16'h0081, 16'h0081, 16'h0001, 16'h0000};
        tbl[2] = '{16'h0001, 16'h0001, 16'h0000, 16'h0080};
        tbl[3] = '{16'hFF00, 16'hFF00, 16'hFF00, 16'h0001};
        tbl[4] = '{16'hFF00, 16'hFF00, 16'h0000, 16'h0000};
        tbl[5] = '{16'h0000, 16'h0000, 16'h0000, 16'hFF00};

        for (int d = 0; d < 2; d++)
            for (int w = 0; w < 5; w++) raw_tb[d][w] = '0;
        raw_tb[0][0] = 16'h0005;
        raw_tb[0][4] = 16'h8000;

        reset = 1'b1;
        step();
        step();
        chk("reset_level_0", 32'(lvl[0][0]), 32'h0);
        chk("reset_ready", 32'(rdy[0]), 32'h0);
        chk("reset_tick", 32'(tck[0]), 32'h0);
        reset = 1'b0;

        // Priming captures raw without pulses
        tick_wait(0);
        chk("prime_level_0", 32'(lvl[0][0]), 32'h0005);
        chk("prime_level_4", 32'(lvl[0][4]), 32'h8000);
        chk("prime_ready", 32'(rdy[0]), 32'h1);
        chk("prime_press_0", 32'(prs[0][0]), 32'h0);
        chk("prime_any", 32'(anyv[0]), 32'h0);

        // Held press needs three ticks
        raw_tb[0][1] = 16'h0008;
        tick_wait(0);
        chk("p1_tick1_press", 32'(prs[0][1]), 32'h0);
        tick_wait(0);
        chk("p1_tick2_press", 32'(prs[0][1]), 32'h0);
        tick_wait(0);
        chk("p1_tick3_press", 32'(prs[0][1]), 32'h0008);
        chk("p1_tick3_any", 32'(anyv[0]), 32'h1);
        chk("p1_tick3_level", 32'(lvl[0][1]), 32'h0008);
        chk("p1_tick3_release", 32'(rls[0][1]), 32'h0);
        step();
        chk("p1_after_press", 32'(prs[0][1]), 32'h0);
        chk("p1_after_any", 32'(anyv[0]), 32'h0);

        // Bounce never flips, then a held value does
        for (int i = 0; i < 4; i++) begin
            raw_tb[0][2] = (i % 2 == 0) ? 16'h0001 : 16'h0000;
            tick_wait(0);
            chk("bounce_level_2", 32'(lvl[0][2]), 32'h0);
            chk("bounce_press_2", 32'(prs[0][2]), 32'h0);
        end
        raw_tb[0][2] = 16'h0001;
        tick_wait(0);
        tick_wait(0);
        chk("held2_press_early", 32'(prs[0][2]), 32'h0);
        tick_wait(0);
        chk("held2_press", 32'(prs[0][2]), 32'h0001);

        // Simultaneous press and release across words
        raw_tb[0][3] = 16'hFFFF;
        raw_tb[0][4] = 16'h0000;
        tick_wait(0);
        tick_wait(0);
        tick_wait(0);
        chk("multi_press_3", 32'(prs[0][3]), 32'hFFFF);
        chk("multi_release_4", 32'(rls[0][4]), 32'h8000);
        chk("multi_any", 32'(anyv[0]), 32'h1);

        // Mid-count reset discards progress and re-primes silently
        raw_tb[0][0] = 16'h0000;
        tick_wait(0);
        tick_wait(0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_reset_ready", 32'(rdy[0]), 32'h0);
        chk("mid_reset_level_0", 32'(lvl[0][0]), 32'h0);
        step();
        chk("post_reset_any", 32'(anyv[0]), 32'h0);
        tick_wait(0);
        chk("reprime_ready", 32'(rdy[0]), 32'h1);
        chk("reprime_release_0", 32'(rls[0][0]), 32'h0);
        chk("reprime_any", 32'(anyv[0]), 32'h0);

        // STABLE_CNT=1 vector table
        tick_wait(1);
        for (int i = 0; i < 6; i++) begin
            raw_tb[1][0] = tbl[i].raw;
            tick_wait(1);
            chk($sformatf("tbl%0d_level", i), 32'(lvl[1][0]), 32'(tbl[i].lvl));
            chk($sformatf("tbl%0d_press", i), 32'(prs[1][0]), 32'(tbl[i].prs));
            chk($sformatf("tbl%0d_release", i), 32'(rls[1][0]), 32'(tbl[i].rls));
            chk($sformatf("tbl%0d_any", i), 32'(anyv[1]), 32'((tbl[i].prs | tbl[i].rls) != 16'h0));
        end

        // One-clock glitch between ticks is not sampled
        raw_tb[1][0] = 16'h0002;
        step();
        raw_tb[1][0] = 16'h0000;
        tick_wait(1);
        chk("glitch_level", 32'(lvl[1][0]), 32'h0);
        chk("glitch_press", 32'(prs[1][0]), 32'h0);

        for (int c = 0; c < 3000; c++) begin
            for (int d = 0; d < 2; d++)
                for (int w = 0; w < 5; w++)
                    if ($urandom_range(0, (d == 0) ? 23 : 5) == 0)
                        raw_tb[d][w] = raw_tb[d][w] ^ 16'($urandom);
            reset = ($urandom_range(0, 499) == 0);
            step();
        end
        reset = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
